mac_tile_scheduler: RTL and testbench

Controller for the TILE_SIZE×TILE_SIZE row-accumulating MAC array. It walks a matrix-vector product (X_PROJ or Δ_t_PROJ) tile by tile. For each row tile it fetches every column tile from the weight/vector buffers and feeds each one to the array. It accumulates the array's per-tile partial sums across column tiles and emits one finished TILE_SIZE-element output vector per row tile through a ready/valid port.

---
 rtl/mac_sched_pkg.sv | 22 ++
 rtl/mac_sched_acc.sv | 74 +++++++
 rtl/mac_tile_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_mac_tile_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types and constants for the MAC tile scheduler.
// Holds the scheduler state encoding, the mode encodings and the
// accumulator width derivation used by the top and the accumulator.
package mac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } sched_state_e;

    localparam logic MODE_XPROJ  = 1'b0;
    localparam logic MODE_DTPROJ = 1'b1;

    // Accumulator lanes carry guard bits above the element width so that
    // summing many column tiles does not overflow before reduction.
    function automatic int acc_width(input int data_width, input int acc_guard);
        return data_width + acc_guard;
    endfunction

endpackage

// File: rtl/mac_sched_acc.sv
// TILE_SIZE-lane accumulator for the MAC tile scheduler.
// A load replaces each lane with the sign-extended array result, an add
// sums it in. out_data is the per-lane reduction of the accumulator to
// DATA_WIDTH: saturating when MAC_SCHED_SAT_EN is defined, otherwise the
// low DATA_WIDTH bits (two's-complement wrap).
module mac_sched_acc #(
    parameter int DATA_WIDTH = 16,
    parameter int TILE_SIZE  = 16,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic                            add,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] in_data,
    output logic [TILE_SIZE*DATA_WIDTH-1:0] out_data
);

    localparam int GUARD = ACC_WIDTH - DATA_WIDTH;

    logic [ACC_WIDTH-1:0] acc_r [TILE_SIZE];

    function automatic logic [ACC_WIDTH-1:0] sign_ext(input logic [DATA_WIDTH-1:0] v);
        return {{GUARD{v[DATA_WIDTH-1]}}, v};
    endfunction

`ifdef MAC_SCHED_SAT_EN
    // A lane fits DATA_WIDTH when every bit from the element sign bit up is
    // identical; otherwise clamp toward the accumulator's sign.
    function automatic logic [DATA_WIDTH-1:0] sat_lane(input logic [ACC_WIDTH-1:0] a);
        logic [GUARD:0]      hi_s;
        logic [DATA_WIDTH-1:0] res_s;
        hi_s = a[ACC_WIDTH-1:DATA_WIDTH-1];
        if ((hi_s == {(GUARD+1){1'b0}}) || (hi_s == {(GUARD+1){1'b1}})) begin
            res_s = a[DATA_WIDTH-1:0];
        end else if (a[ACC_WIDTH-1]) begin
            res_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            res_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return res_s;
    endfunction
`endif

    // Lane accumulators: load on the first return of a row tile, add afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TILE_SIZE; i++) begin
                acc_r[i] <= {ACC_WIDTH{1'b0}};
            end
        end else if (load) begin
            for (int i = 0; i < TILE_SIZE; i++) begin
                acc_r[i] <= sign_ext(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end else if (add) begin
            for (int i = 0; i < TILE_SIZE; i++) begin
                acc_r[i] <= acc_r[i] + sign_ext(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // Per-lane reduction of the accumulator registers to the output width.
    always_comb begin
        out_data = {(TILE_SIZE*DATA_WIDTH){1'b0}};
        for (int i = 0; i < TILE_SIZE; i++) begin
`ifdef MAC_SCHED_SAT_EN
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = sat_lane(acc_r[i]);
`else
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = acc_r[i][DATA_WIDTH-1:0];
`endif
        end
    end

endmodule

// File: rtl/mac_tile_scheduler.sv
// MAC tile scheduler top: walks a matrix-vector product tile by tile,
// issues buffer reads for every column tile of each row tile, accumulates
// the array's partial sums and hands one output vector per row tile to a
// ready/valid consumer.
// Optional feature macro: MAC_SCHED_SAT_EN (saturating output reduction;
// default build wraps).
module mac_tile_scheduler
    import mac_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TILE_SIZE  = 16,
    parameter int CNT_W      = 8,
    parameter int ACC_GUARD  = 8,
    parameter int MEM_LAT    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            mode,
    input  logic [CNT_W-1:0]                n_row_tiles,
    input  logic [CNT_W-1:0]                n_col_tiles,
    output logic                            busy,
    output logic                            done,
    output logic                            rd_en,
    output logic [CNT_W-1:0]                rd_row_idx,
    output logic [CNT_W-1:0]                rd_col_idx,
    output logic                            arr_valid_in,
    output logic                            arr_mode,
    input  logic                            arr_valid_out,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] arr_result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [TILE_SIZE*DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]                out_row_idx,
    output logic                            err_unexp
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ACC_GUARD);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   OUT_ZERO = {(CNT_W+1){1'b0}};
    localparam logic [CNT_W:0]   OUT_ONE  = {{CNT_W{1'b0}}, 1'b1};

    sched_state_e state_r, state_nxt;
    logic             busy_r, busy_nxt;
    logic             done_r, done_nxt;
    logic             rd_en_r, rd_en_nxt;
    logic [CNT_W-1:0] rd_col_r, rd_col_nxt;
    logic [CNT_W-1:0] row_r, row_nxt;
    logic [CNT_W-1:0] ret_cnt_r, ret_cnt_nxt;
    logic             out_valid_r, out_valid_nxt;
    logic [CNT_W-1:0] n_row_r, n_row_nxt;
    logic [CNT_W-1:0] n_col_r, n_col_nxt;
    logic             mode_r, mode_nxt;
    logic [CNT_W:0]   outst_r;
    logic             err_r;
    logic [MEM_LAT-1:0] dly_r;

    logic             accept_s;
    logic [CNT_W-1:0] ret_inc_s;
    logic             last_col_s;
    logic             last_row_s;
    logic             xfer_s;
    logic             acc_load_s;
    logic             acc_add_s;

    // A return only counts while at least one issued tile is still unanswered.
    assign accept_s   = arr_valid_out && (outst_r != OUT_ZERO);
    assign ret_inc_s  = ret_cnt_r + CNT_ONE;
    assign last_col_s = (rd_col_r == (n_col_r - CNT_ONE));
    assign last_row_s = (row_r == (n_row_r - CNT_ONE));
    assign xfer_s     = out_valid_r && out_ready;
    assign acc_load_s = accept_s && (ret_cnt_r == CNT_ZERO);
    assign acc_add_s  = accept_s && (ret_cnt_r != CNT_ZERO);

    mac_sched_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .TILE_SIZE  (TILE_SIZE),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .load     (acc_load_s),
        .add      (acc_add_s),
        .in_data  (arr_result),
        .out_data (out_data)
    );

    // Next-state and next-output logic of the tile walk.
    always_comb begin
        state_nxt     = state_r;
        busy_nxt      = busy_r;
        done_nxt      = 1'b0;
        rd_en_nxt     = rd_en_r;
        rd_col_nxt    = rd_col_r;
        row_nxt       = row_r;
        ret_cnt_nxt   = accept_s ? ret_inc_s : ret_cnt_r;
        out_valid_nxt = out_valid_r;
        n_row_nxt     = n_row_r;
        n_col_nxt     = n_col_r;
        mode_nxt      = mode_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if ((n_row_tiles != CNT_ZERO) && (n_col_tiles != CNT_ZERO)) begin
                        state_nxt   = ISSUE;
                        busy_nxt    = 1'b1;
                        rd_en_nxt   = 1'b1;
                        rd_col_nxt  = CNT_ZERO;
                        row_nxt     = CNT_ZERO;
                        ret_cnt_nxt = CNT_ZERO;
                        n_row_nxt   = n_row_tiles;
                        n_col_nxt   = n_col_tiles;
                        mode_nxt    = (mode == MODE_DTPROJ) ? MODE_DTPROJ : MODE_XPROJ;
                    end else begin
                        // Empty job: finish immediately without touching the buffers.
                        done_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (last_col_s) begin
                    state_nxt = DRAIN;
                    rd_en_nxt = 1'b0;
                end else begin
                    rd_col_nxt = rd_col_r + CNT_ONE;
                    rd_en_nxt  = 1'b1;
                end
            end
            DRAIN: begin
                if ((accept_s && (ret_inc_s == n_col_r)) || (ret_cnt_r == n_col_r)) begin
                    state_nxt     = OUTPUT;
                    out_valid_nxt = 1'b1;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            OUTPUT: begin
                if (xfer_s) begin
                    out_valid_nxt = 1'b0;
                    if (last_row_s) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt   = ISSUE;
                        row_nxt     = row_r + CNT_ONE;
                        ret_cnt_nxt = CNT_ZERO;
                        rd_en_nxt   = 1'b1;
                        rd_col_nxt  = CNT_ZERO;
                    end
                end else begin
                    state_nxt = OUTPUT;
                end
            end
            default: begin
                state_nxt     = IDLE;
                busy_nxt      = 1'b0;
                rd_en_nxt     = 1'b0;
                out_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            rd_col_r    <= CNT_ZERO;
            row_r       <= CNT_ZERO;
            ret_cnt_r   <= CNT_ZERO;
            out_valid_r <= 1'b0;
            n_row_r     <= CNT_ZERO;
            n_col_r     <= CNT_ZERO;
            mode_r      <= MODE_XPROJ;
        end else begin
            state_r     <= state_nxt;
            busy_r      <= busy_nxt;
            done_r      <= done_nxt;
            rd_en_r     <= rd_en_nxt;
            rd_col_r    <= rd_col_nxt;
            row_r       <= row_nxt;
            ret_cnt_r   <= ret_cnt_nxt;
            out_valid_r <= out_valid_nxt;
            n_row_r     <= n_row_nxt;
            n_col_r     <= n_col_nxt;
            mode_r      <= mode_nxt;
        end
    end

    // Outstanding tile count (issued minus returned) and sticky unexpected-return flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_r <= OUT_ZERO;
            err_r   <= 1'b0;
        end else begin
            case ({rd_en_r, accept_s})
                2'b10:   outst_r <= outst_r + OUT_ONE;
                2'b01:   outst_r <= outst_r - OUT_ONE;
                default: outst_r <= outst_r;
            endcase
            if (arr_valid_out && (outst_r == OUT_ZERO) && busy_r) begin
                err_r <= 1'b1;
            end
        end
    end

    // Delay rd_en by the buffer read latency to qualify the array input.
    generate
        if (MEM_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_r <= 1'b0;
                end else begin
                    dly_r <= rd_en_r;
                end
            end
        end else begin : g_latn
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_r <= {MEM_LAT{1'b0}};
                end else begin
                    dly_r <= {dly_r[MEM_LAT-2:0], rd_en_r};
                end
            end
        end
    endgenerate

    assign busy         = busy_r;
    assign done         = done_r;
    assign rd_en        = rd_en_r;
    assign rd_row_idx   = row_r;
    assign rd_col_idx   = rd_col_r;
    assign arr_valid_in = dly_r[MEM_LAT-1];
    assign arr_mode     = mode_r;
    assign out_valid    = out_valid_r;
    assign out_row_idx  = row_r;
    assign err_unexp    = err_r;

endmodule

// File: tb/tb_mac_tile_scheduler.sv
// Scoreboard bench for mac_tile_scheduler: jobs push expected output
// vectors into a queue, a monitor pops and compares on every transfer.
// A small array model answers each arr_valid_in after a programmable delay.
module tb_mac_tile_scheduler;

    localparam int DW = 16;
    localparam int TS = 16;
    localparam int CW = 8;
    localparam int VW = TS * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [CW-1:0] n_row_tiles;
    logic [CW-1:0] n_col_tiles;
    logic          busy, done, rd_en, arr_valid_in, arr_mode;
    logic [CW-1:0] rd_row_idx, rd_col_idx, out_row_idx;
    logic          arr_valid_out;
    logic [VW-1:0] arr_result;
    logic          out_valid, out_ready, err_unexp;
    logic [VW-1:0] out_data;

    always #5 clk = ~clk;

    mac_tile_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .n_row_tiles   (n_row_tiles),
        .n_col_tiles   (n_col_tiles),
        .busy          (busy),
        .done          (done),
        .rd_en         (rd_en),
        .rd_row_idx    (rd_row_idx),
        .rd_col_idx    (rd_col_idx),
        .arr_valid_in  (arr_valid_in),
        .arr_mode      (arr_mode),
        .arr_valid_out (arr_valid_out),
        .arr_result    (arr_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_row_idx   (out_row_idx),
        .err_unexp     (err_unexp)
    );

    typedef struct {
        logic [CW-1:0] row;
        logic [VW-1:0] data;
    } sb_t;

    sb_t sb_q[$];
    int  tests = 0;
    int  fails = 0;
    int  rd_cnt = 0, avi_cnt = 0, done_cnt = 0, ov_cnt = 0, lat_err = 0;
    int  arr_lat = 2;
    int  cyc = 0;
    int  due_q[$];
    bit  inj_req = 1'b0;
    logic [DW-1:0] ret_base = 16'h0000;
    logic [DW-1:0] ret_step = 16'h0000;

    task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_val(input int i);
        logic [DW-1:0] idx;
        idx = DW'(i);
        return ret_base + ret_step * idx;
    endfunction

    // Reference: nc identical returns summed at full precision, then reduced.
    function automatic logic [DW-1:0] exp_lane(input int nc, input logic [DW-1:0] v);
        int s;
        s = nc * int'(signed'(v));
`ifdef MAC_SCHED_SAT_EN
        if (s > 32767) return 16'h7FFF;
        else if (s < -32768) return 16'h8000;
        else return s[15:0];
`else
        return s[15:0];
`endif
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int nc);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < TS; i++) v[i*DW +: DW] = exp_lane(nc, lane_val(i));
        return v;
    endfunction

    // Array model: each arr_valid_in answered arr_lat cycles later; optional injection.
    initial begin
        arr_valid_out = 1'b0;
        arr_result = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (arr_valid_in === 1'b1) due_q.push_back(cyc + arr_lat);
            arr_valid_out = 1'b0;
            for (int i = 0; i < TS; i++) arr_result[i*DW +: DW] = lane_val(i);
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                due_q.pop_front();
                arr_valid_out = 1'b1;
            end
            if (inj_req) begin
                arr_valid_out = 1'b1;
                for (int i = 0; i < TS; i++) arr_result[i*DW +: DW] = 16'h1111;
                inj_req = 1'b0;
            end
        end
    end

    // Monitor: event counters plus scoreboard pop on every output transfer.
    initial begin
        sb_t e;
        logic prev_rd;
        logic prev_rst;
        prev_rd = 1'b0;
        prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            if (rd_en) rd_cnt++;
            if (arr_valid_in) avi_cnt++;
            if (done) done_cnt++;
            if (out_valid) ov_cnt++;
            if (!prev_rst && (arr_valid_in !== prev_rd)) lat_err++;
            prev_rd = rd_en;
            prev_rst = rst;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_row_idx", out_row_idx, e.row);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input int nr, input int nc, input logic [DW-1:0] base,
                             input logic [DW-1:0] stp, input logic md, input bit push);
        sb_t e;
        ret_base = base;
        ret_step = stp;
        if (push) begin
            for (int r = 0; r < nr; r++) begin
                e.row = CW'(r);
                e.data = exp_vec(nc);
                sb_q.push_back(e);
            end
        end
        n_row_tiles = CW'(nr);
        n_col_tiles = CW'(nc);
        mode = md;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 500) begin
            step(1);
            k++;
        end
        check({nm, "_done_seen"}, (done_cnt > d0), 1'b1);
        step(3);
        check({nm, "_done_once"}, done_cnt - d0, 1);
        check({nm, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic wait_ov(input string nm);
        int k;
        k = 0;
        while (!out_valid && k < 200) begin
            step(1);
            k++;
        end
        check({nm, "_ov_seen"}, out_valid, 1'b1);
    endtask

    task automatic push_const(input logic [CW-1:0] row, input logic [DW-1:0] lane);
        sb_t e;
        e.row = row;
        for (int i = 0; i < TS; i++) e.data[i*DW +: DW] = lane;
        sb_q.push_back(e);
    endtask

    initial begin
        int d0, r0, o0;
        logic [VW-1:0] hold;
        bit stable, seen;
        logic [DW-1:0] sat_pos, sat_neg;
`ifdef MAC_SCHED_SAT_EN
        sat_pos = 16'h7FFF;
        sat_neg = 16'h8000;
`else
        sat_pos = 16'hC000;
        sat_neg = 16'h4000;
`endif
        rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b1;
        n_row_tiles = '0; n_col_tiles = '0;
        step(3);
        rst = 1'b0;
        check("rst_ctrl", {busy, done, rd_en, arr_valid_in, out_valid, err_unexp, arr_mode}, 7'b0);
        check("rst_idx", {rd_row_idx, rd_col_idx, out_row_idx}, 24'h0);
        check("rst_out_data", out_data, '0);

        // 2 rows x 3 cols, lanes 5 -> 15, consumer always ready.
        d0 = done_cnt; r0 = rd_cnt;
        start_job(2, 3, 16'd5, 16'd0, 1'b0, 1'b1);
        check("t1_busy_t1", busy, 1'b1);
        check("t1_rd_en_t1", rd_en, 1'b1);
        wait_done(d0, "t1");
        check("t1_rd_cycles", rd_cnt - r0, 6);

        // Same job, consumer stalls 10 cycles on the first vector.
        out_ready = 1'b0;
        d0 = done_cnt;
        start_job(2, 3, 16'd5, 16'd0, 1'b1, 1'b1);
        check("t2_arr_mode", arr_mode, 1'b1);
        wait_ov("t2");
        hold = out_data; r0 = rd_cnt; stable = 1'b1;
        repeat (10) begin
            step(1);
            if (out_data !== hold || out_valid !== 1'b1) stable = 1'b0;
        end
        check("t2_hold_stable", stable, 1'b1);
        check("t2_no_reads_held", rd_cnt - r0, 0);
        check("t2_held_value", hold, {TS{16'd15}});
        out_ready = 1'b1;
        wait_done(d0, "t2");

        // Positive overflow: 4 x 0x7000.
        d0 = done_cnt;
        push_const(8'd0, sat_pos);
        start_job(1, 4, 16'h7000, 16'd0, 1'b0, 1'b0);
        wait_done(d0, "t3");

        // Negative overflow: 4 x 0x9000.
        d0 = done_cnt;
        push_const(8'd0, sat_neg);
        start_job(1, 4, 16'h9000, 16'd0, 1'b0, 1'b0);
        wait_done(d0, "t3n");

        // Per-lane negative ramp, 3 rows x 2 cols; a start mid-job is ignored.
        d0 = done_cnt; r0 = rd_cnt;
        start_job(3, 2, 16'hFFFD, 16'd1, 1'b0, 1'b1);
        n_row_tiles = 8'd1; n_col_tiles = 8'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(d0, "t4");
        check("t4_rd_cycles", rd_cnt - r0, 6);

        // Zero-sized jobs: done at T+1, nothing else happens.
        d0 = done_cnt; r0 = rd_cnt; o0 = ov_cnt;
        start_job(0, 3, 16'd1, 16'd0, 1'b0, 1'b0);
        check("t5_done_t1", done, 1'b1);
        check("t5_busy", busy, 1'b0);
        step(1);
        start_job(2, 0, 16'd1, 16'd0, 1'b0, 1'b0);
        check("t5c_done_t1", done, 1'b1);
        step(4);
        check("t5_no_reads", rd_cnt - r0, 0);
        check("t5_no_out", ov_cnt - o0, 0);
        check("t5_done_count", done_cnt - d0, 2);

        // Unexpected returns: ignored while idle, flagged while busy.
        inj_req = 1'b1;
        step(3);
        check("t6_err_idle", err_unexp, 1'b0);
        out_ready = 1'b0;
        d0 = done_cnt;
        start_job(1, 2, 16'd7, 16'd0, 1'b0, 1'b1);
        wait_ov("t6");
        inj_req = 1'b1;
        step(2);
        check("t6_err_busy", err_unexp, 1'b1);
        check("t6_data_intact", out_data, {TS{16'd14}});
        out_ready = 1'b1;
        wait_done(d0, "t6");
        check("t6_err_sticky", err_unexp, 1'b1);

        // Reset in DRAIN with two returns still in flight.
        arr_lat = 6;
        o0 = ov_cnt;
        start_job(1, 3, 16'd9, 16'd0, 1'b1, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = arr_valid_out;
        end
        check("t7_first_return", seen, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sb_q.delete();
        check("t7_rst_ctrl", {busy, done, rd_en, arr_valid_in, out_valid, err_unexp, arr_mode}, 7'b0);
        check("t7_rst_idx", {rd_row_idx, rd_col_idx, out_row_idx}, 24'h0);
        check("t7_rst_data", out_data, '0);
        step(10);
        check("t7_err_after", err_unexp, 1'b0);
        check("t7_busy_after", busy, 1'b0);
        check("t7_no_out", ov_cnt - o0, 0);
        arr_lat = 2;
        d0 = done_cnt;
        start_job(1, 2, 16'd3, 16'd2, 1'b0, 1'b1);
        wait_done(d0, "t8");

        check("avi_tracks_rd_en", lat_err, 0);
        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
